// File: rtl/softusb_navre_uart.sv
// UART peripheral on the navre I/O bus: 4-deep TX FIFO feeding a shifter,
// synchronised mid-bit RX sampler with one holding register, 16-bit baud divisor.
module softusb_navre_uart #(
    parameter logic [5:0]  base        = 6'h20,
    parameter logic [15:0] default_div = 16'd433
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [5:0] io_a,
    input  logic [7:0] io_do,
    output logic [7:0] io_di,
    input  logic       uart_rx,
    output logic       uart_tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [5:0]  offset;
    logic        sel, data_wr, data_rd, status_wr;
    logic [15:0] div;
    logic        rx_valid, rx_overrun, tx_overflow, frame_err, tx_idle;
    logic [7:0]  read_val;

    assign offset    = io_a - base;
    assign sel       = (offset[5:2] == 4'd0);
    assign data_wr   = io_we && sel && (offset[1:0] == 2'd0);
    assign data_rd   = io_re && sel && (offset[1:0] == 2'd0);
    assign status_wr = io_we && sel && (offset[1:0] == 2'd1);

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_count;
    logic       tx_pop, push_ok;

    // a full FIFO still accepts a push when the shifter frees a slot on the same edge
    assign push_ok = data_wr && ((fifo_count != 3'd4) || tx_pop);

    state_t      tx_state, tx_state_next;
    logic [15:0] tx_timer, tx_timer_next;
    logic [2:0]  tx_idx, tx_idx_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_end, tx_line_next;

    assign tx_end  = (tx_timer == 16'd0);
    assign tx_idle = (fifo_count == 3'd0) && (tx_state == IDLE);

    always_comb begin
        tx_state_next = tx_state;
        tx_timer_next = (tx_state == IDLE || tx_end) ? div : tx_timer - 16'd1;
        tx_idx_next   = tx_idx;
        tx_shift_next = tx_shift;
        tx_pop        = 1'b0;
        case (tx_state)
            IDLE: if (fifo_count != 3'd0) begin
                tx_pop        = 1'b1;
                tx_shift_next = fifo_mem[rd_ptr];
                tx_state_next = START;
            end
            START: if (tx_end) begin
                tx_state_next = DATA;
                tx_idx_next   = 3'd0;
            end
            DATA: if (tx_end) begin
                tx_shift_next = {1'b0, tx_shift[7:1]};
                tx_idx_next   = tx_idx + 3'd1;
                if (tx_idx == 3'd7) tx_state_next = STOP;
            end
            STOP: if (tx_end) begin
                if (fifo_count != 3'd0) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = fifo_mem[rd_ptr];
                    tx_state_next = START;
                end else begin
                    tx_state_next = IDLE;
                end
            end
        endcase
        if (tx_state_next == START)     tx_line_next = 1'b0;
        else if (tx_state_next == DATA) tx_line_next = tx_shift_next[0];
        else                            tx_line_next = 1'b1;
    end

    logic        rx_s1, rx_s2, rx_prev;
    state_t      rx_state, rx_state_next;
    logic [15:0] rx_timer, rx_timer_next;
    logic [2:0]  rx_idx, rx_idx_next;
    logic [7:0]  rx_shift, rx_shift_next, rx_hold;
    logic        rx_end, rx_done, rx_bad;

    assign rx_end = (rx_timer == 16'd0);

    always_comb begin
        rx_state_next = rx_state;
        rx_timer_next = rx_end ? div : rx_timer - 16'd1;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_done       = 1'b0;
        rx_bad        = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_timer_next = {1'b0, div[15:1]};
                if (rx_prev && !rx_s2) rx_state_next = START;
            end
            START: if (rx_end) begin
                rx_state_next = rx_s2 ? IDLE : DATA;
                rx_idx_next   = 3'd0;
            end
            DATA: if (rx_end) begin
                rx_shift_next = {rx_s2, rx_shift[7:1]};
                rx_idx_next   = rx_idx + 3'd1;
                if (rx_idx == 3'd7) rx_state_next = STOP;
            end
            STOP: if (rx_end) begin
                rx_done       = rx_s2;
                rx_bad        = !rx_s2;
                rx_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        read_val = 8'h00;
        case (offset[1:0])
            2'd0: read_val = rx_hold;
            2'd1: read_val = {2'b00, frame_err, tx_overflow, rx_overrun, rx_valid, tx_idle,
                              (fifo_count == 3'd4)};
            2'd2: read_val = div[7:0];
            2'd3: read_val = div[15:8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= io_do;
        tx_shift <= tx_shift_next;
        rx_shift <= rx_shift_next;
        if (rx_done) rx_hold <= rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            fifo_count  <= 3'd0;
            tx_state    <= IDLE;
            tx_timer    <= 16'd0;
            tx_idx      <= 3'd0;
            uart_tx     <= 1'b1;
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= IDLE;
            rx_timer    <= 16'd0;
            rx_idx      <= 3'd0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            frame_err   <= 1'b0;
            div         <= default_div;
            io_di       <= 8'h00;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (tx_pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b00, push_ok} - {2'b00, tx_pop};
            tx_state   <= tx_state_next;
            tx_timer   <= tx_timer_next;
            tx_idx     <= tx_idx_next;
            uart_tx    <= tx_line_next;
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_next;
            rx_timer   <= rx_timer_next;
            rx_idx     <= rx_idx_next;
            // set events win over a clearing write on the same edge
            rx_valid    <= rx_done | (rx_valid & ~data_rd);
            rx_overrun  <= (rx_done & rx_valid & ~data_rd) | (rx_overrun & ~(status_wr & io_do[3]));
            tx_overflow <= (data_wr & ~push_ok) | (tx_overflow & ~(status_wr & io_do[4]));
            frame_err   <= rx_bad | (frame_err & ~(status_wr & io_do[5]));
            if (io_we && sel && offset[1:0] == 2'd2) div[7:0]  <= io_do;
            if (io_we && sel && offset[1:0] == 2'd3) div[15:8] <= io_do;
            io_di <= (io_re && sel) ? read_val : 8'h00;
        end
    end
endmodule

// File: tb/tb_softusb_navre_uart.sv
// Bench for softusb_navre_uart: queue-based line/register model checked every
// cycle, plus directed register and waveform expectations.
module tb_softusb_navre_uart;
    localparam logic [5:0] BASE   = 6'h20;
    localparam logic [5:0] A_DATA = BASE;
    localparam logic [5:0] A_STAT = BASE + 6'd1;
    localparam logic [5:0] A_DIVL = BASE + 6'd2;
    localparam logic [5:0] A_DIVH = BASE + 6'd3;
    localparam logic [5:0] A_NONE = BASE + 6'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_re = 1'b0, io_we = 1'b0;
    logic [5:0] io_a = 6'd0;
    logic [7:0] io_do = 8'd0;
    logic [7:0] io_di;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    int         n_checks = 0, n_fail = 0;

    softusb_navre_uart #(.base(BASE), .default_div(16'd433)) dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_do(io_do), .io_di(io_di), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Model: bytes waiting in the FIFO, and the line levels of the frame in flight.
    logic [15:0] m_div = 16'd433;
    logic [7:0]  m_hold = 8'h00;
    logic        m_valid = 1'b0, m_ovr = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
    logic [7:0]  pend [$];
    logic        wave [$];
    logic        exp_tx = 1'b1;
    logic [7:0]  exp_di = 8'h00;
    int          rx_evt_cnt = 0, rx_seen = 0;
    logic [7:0]  rx_evt_byte = 8'h00;
    logic        rx_evt_good = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic [5:0] off;
        logic       msel, rd_data, ovf_set, lvl, valid_new;
        logic [7:0] b;
        if (rst) begin
            pend.delete();
            wave.delete();
            m_div   = 16'd433;
            m_valid = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
            exp_tx  = 1'b1;
            exp_di  = 8'h00;
            rx_seen = rx_evt_cnt;
        end else begin
            off     = io_a - BASE;
            msel    = (off < 6'd4);
            rd_data = io_re && msel && (off == 6'd0);
            exp_di  = 8'h00;
            if (io_re && msel) begin
                case (off[1:0])
                    2'd0:    exp_di = m_hold;
                    2'd1:    exp_di = {2'b00, m_ferr, m_ovf, m_ovr, m_valid,
                                       (pend.size() == 0 && wave.size() == 0), (pend.size() == 4)};
                    2'd2:    exp_di = m_div[7:0];
                    default: exp_di = m_div[15:8];
                endcase
            end
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && pend.size() > 0) begin
                b = pend.pop_front();
                for (int i = 0; i < 10; i++) begin
                    if (i == 0)      lvl = 1'b0;
                    else if (i == 9) lvl = 1'b1;
                    else             lvl = b[i-1];
                    repeat (int'(m_div) + 1) wave.push_back(lvl);
                end
            end
            ovf_set = 1'b0;
            if (io_we && msel && off == 6'd0) begin
                if (pend.size() < 4) pend.push_back(io_do);
                else ovf_set = 1'b1;
            end
            if (io_we && msel && off == 6'd1) begin
                if (io_do[3]) m_ovr  = 1'b0;
                if (io_do[4]) m_ovf  = 1'b0;
                if (io_do[5]) m_ferr = 1'b0;
            end
            if (io_we && msel && off == 6'd2) m_div[7:0]  = io_do;
            if (io_we && msel && off == 6'd3) m_div[15:8] = io_do;
            if (ovf_set) m_ovf = 1'b1;
            valid_new = m_valid & ~rd_data;
            if (rx_seen != rx_evt_cnt) begin
                rx_seen = rx_evt_cnt;
                if (rx_evt_good) begin
                    if (m_valid && !rd_data) m_ovr = 1'b1;
                    m_hold    = rx_evt_byte;
                    valid_new = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end
            m_valid = valid_new;
            exp_tx  = (wave.size() > 0) ? wave[0] : 1'b1;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("tx_line", {7'd0, uart_tx}, {7'd0, exp_tx});
        check("io_di", io_di, exp_di);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_a = a; io_do = d; io_we = 1'b1;
        tick();
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        io_a = a; io_re = 1'b1;
        tick();
        io_re = 1'b0;
        d = io_di;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int per);
        uart_rx = 1'b0;
        repeat (per) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (per) tick();
        end
        uart_rx = stop_bit;
        repeat (per) tick();
        uart_rx = 1'b1;
        repeat (8) tick();
        rx_evt_byte = b;
        rx_evt_good = stop_bit;
        rx_evt_cnt++;
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] d;
        logic       lvl [10];
        lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        check("reset_tx", {7'd0, uart_tx}, 8'd1);
        check("reset_di", io_di, 8'd0);
        rst = 1'b0;
        tick();
        rd(A_STAT, d); check("status_reset", d, 8'h02);
        rd(A_DIVL, d); check("divl_reset", d, 8'hB1);
        rd(A_DIVH, d); check("divh_reset", d, 8'h01);
        rd(A_NONE, d); check("unmapped_rd", d, 8'h00);

        wr(A_DIVL, 8'd3);
        wr(A_DIVH, 8'd0);
        wr(A_DATA, 8'hA5);
        tick();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                check("a5_wave", {7'd0, uart_tx}, {7'd0, lvl[i]});
                tick();
            end
        end
        rd(A_STAT, d); check("a5_idle", d & 8'h02, 8'h02);

        for (int k = 1; k <= 6; k++) wr(A_DATA, 8'(k));
        rd(A_STAT, d);
        check("ovf_set", d & 8'h10, 8'h10);
        check("fifo_full", d & 8'h01, 8'h01);
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (t % 40 == 34) check("b2b_stop", {7'd0, uart_tx}, 8'd1);
            if (t % 40 == 35) check("b2b_start", {7'd0, uart_tx}, (t < 195) ? 8'd0 : 8'd1);
        end
        wr(A_STAT, 8'h10);
        rd(A_STAT, d); check("ovf_clear", d, 8'h02);

        rx_send(8'h3C, 1'b1, 4);
        rd(A_STAT, d); check("rx_status", d, 8'h06);
        rd(A_DATA, d); check("rx_data", d, 8'h3C);
        rd(A_STAT, d); check("rx_valid_clr", d, 8'h02);

        rx_send(8'h11, 1'b1, 4);
        rx_send(8'h22, 1'b1, 4);
        rd(A_STAT, d); check("overrun_status", d, 8'h0E);
        rd(A_DATA, d); check("overrun_data", d, 8'h22);
        wr(A_STAT, 8'h08);
        rx_send(8'h77, 1'b1, 4);
        rx_send(8'h55, 1'b0, 4);
        rd(A_STAT, d); check("ferr_status", d, 8'h26);
        rd(A_DATA, d); check("ferr_data", d, 8'h77);
        wr(A_STAT, 8'h20);
        rd(A_STAT, d); check("ferr_clear", d, 8'h02);

        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        rd(A_STAT, d); check("glitch_status", d, 8'h02);
        rx_send(8'h5A, 1'b1, 4);
        rd(A_DATA, d); check("after_glitch", d, 8'h5A);

        wr(A_DIVL, 8'd0);
        wr(A_DATA, 8'h96);
        tick(); check("div0_start", {7'd0, uart_tx}, 8'd0);
        tick(); check("div0_bit0", {7'd0, uart_tx}, 8'd0);
        tick(); check("div0_bit1", {7'd0, uart_tx}, 8'd1);
        repeat (12) tick();
        rd(A_STAT, d); check("div0_idle", d, 8'h02);

        wr(A_DIVL, 8'd3);
        wr(A_DATA, 8'h00);
        wr(A_DATA, 8'h00);
        repeat (10) tick();
        check("pre_rst_tx", {7'd0, uart_tx}, 8'd0);
        rst = 1'b1;
        #1;
        check("rst_tx", {7'd0, uart_tx}, 8'd1);
        check("rst_di", io_di, 8'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rd(A_STAT, d); check("rst_fifo_empty", d, 8'h02);
        rd(A_DIVL, d); check("rst_div", d, 8'hB1);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/softusb_navre_uart.md
Name: softusb_navre_uart

Overview:
- Memory-mapped UART peripheral on the softusb_navre I/O bus (io_re/io_we/io_a/io_do/io_di); the core is its master.
- Transmit path: 4-entry TX FIFO feeding a shifter.
- Receive path: synchronised RX line, mid-bit sampler, single holding register.
- Provides the firmware console/debug channel and a byte-level test target for navre programs.

Parameters:
- base, 6'h20, I/O address of register 0; registers occupy base..base+3.
- default_div, 16'd433, reset value of baud divisor; bit period = div+1 clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- io_re  input  1  core I/O read strobe, one cycle.
- io_we  input  1  core I/O write strobe, one cycle.
- io_a  input  6  I/O address.
- io_do  input  8  write data from core.
- io_di  output  8  read data to core; 0 when not selected, so it can be OR-combined with other slaves.
- uart_rx  input  1  serial in, asynchronous, idle high.
- uart_tx  output  1  serial out, idle high.

Behaviour:
- Reset (asynchronous, immediate): uart_tx=1, io_di=0, FIFO empty, TX state IDLE, RX state IDLE, rx_valid=0, all flags 0, div=default_div. Reset mid-frame aborts the frame and forces uart_tx high at once.
- Register map (offset from base):
  - +0 DATA: write pushes the TX FIFO. Read returns the RX holding byte and clears rx_valid.
  - +1 STATUS, read:
    - bit0 tx_full (count=4)
    - bit1 tx_idle (FIFO empty and shifter IDLE)
    - bit2 rx_valid
    - bit3 rx_overrun
    - bit4 tx_overflow
    - bit5 frame_err
    - bits7:6 = 0
  - +1 STATUS, write: writing 1 to bits 3/4/5 clears that flag; other bits ignored.
  - +2 DIVL, +3 DIVH: read/write the divisor bytes. A new divisor takes effect at the next bit boundary.
- Read timing: io_di is registered. When io_re is high with a matching address, io_di = register value on the next cycle; in every other cycle io_di=0. Read side effects (rx_valid clear) occur in the same edge that loads io_di.
- Strobes: io_re and io_we are never asserted together. Accesses to unmatched addresses are ignored.
- TX FIFO: depth 4, 2-bit pointers wrapping modulo 4, 3-bit count.
  - Push is accepted if count<4, or if the shifter pops in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO non-empty, pop into the shift register and enter START.
  - START: drive 0 for div+1 clocks.
  - DATA: 8 bits LSB first, div+1 clocks each; a 3-bit bit index wraps from 7 to STOP.
  - STOP: drive 1 for div+1 clocks. At the end, pop the next byte directly if one is available (back-to-back frames, no extra idle clock); else go to IDLE.
  - Bit timer: 16-bit down-counter loaded with div, bit ends at 0.
- RX path: 2-flop synchroniser on uart_rx. A falling edge of the synchronised line in IDLE starts reception.
  - START: wait (div>>1)+1 clocks, then sample. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA: 8 samples at div+1 spacing, LSB first.
  - STOP: sample once. If 1, load the holding register and set rx_valid; if 0, discard the byte and set frame_err. Then go to IDLE.
- RX boundary cases:
  - Frame completes while rx_valid=1 and no DATA read that cycle: overwrite the holding byte and set rx_overrun.
  - Frame completes in the same cycle as a DATA read: io_di gets the old byte, the new byte loads, rx_valid stays 1, no overrun.
- Flag precedence: a set event and a clear write in the same cycle leave the flag set.
- Divisor: 16-bit; div=0 gives 1 clock per bit and must work, half-bit wait = 1 clock.

Test Plan:
- Reset -> uart_tx=1, io_di=0. Then read base+1 -> io_di=8'h02 the next cycle. Read base+2/base+3 -> 8'hB1/8'h01.
- Write DIVL=3, DIVH=0, then write DATA=8'hA5 -> uart_tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. STATUS bit1 returns to 1 after 40 clocks.
- With div=3, write 6 bytes 8'h01..8'h06 back-to-back -> 8'h01..8'h05 transmitted as contiguous frames with no idle gap, 8'h06 dropped, STATUS bit4=1. Write 8'h10 to base+1 -> bit4 clears.
- With div=3, drive a 4-clock-per-bit frame of 8'h3C on uart_rx -> STATUS=8'h06 after the stop bit. Read DATA -> 8'h3C, and STATUS bit2 then 0.
- Two received frames (8'h11, 8'h22) with no read in between -> DATA reads 8'h22, STATUS bit3=1. A frame whose stop bit is 0 -> byte discarded, bit5=1, rx_valid unchanged.
- Other boundary cases:
  - 1-clock low glitch on uart_rx -> no reception, RX returns to IDLE.
  - Assert rst mid-TX-frame -> uart_tx=1 in the same cycle, FIFO empty after reset.
  - Read an unmapped address (base+4) -> io_di stays 0.
